// File: rtl/riscv_fetch_fifo_gen.sv
// riscv_fetch_fifo_gen: prefetch FIFO that realigns RVC/RV32 instructions across 32-bit words
// in_*: words from the prefetcher; in_ready_o keeps one slot free for the word already in flight
// out_*: one aligned instruction per handshake to IF; out_valid_stored_o ignores the bypass path
// level_o/almost_full_o: registered occupancy after write and pop; overflow_o: sticky dropped write
module riscv_fetch_fifo_gen #(
  parameter int DEPTH = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic [ADDR_WIDTH-1:0] in_addr_i,
  input  logic [31:0]           in_rdata_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  in_replace2_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [31:0]           out_rdata_o,
  output logic [ADDR_WIDTH-1:0] out_addr_o,
  output logic                  out_is_compressed_o,
  output logic                  out_valid_stored_o,
  output logic [LVL_W-1:0]      level_o,
  output logic                  almost_full_o,
  output logic                  overflow_o
);
  logic [DEPTH-1:0] valid_q, valid_n;
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_n [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [31:0] data_n [DEPTH];
  logic [LVL_W-1:0] level_n;
  logic [31:0] w0;
  logic [15:0] w1;
  logic [ADDR_WIDTH-1:0] a;
  logic [ADDR_WIDTH-3:0] a_next;
  logic ovf_q, ovf_n, pop, shift, ua32, rep, placed;
  assign w0 = valid_q[0] ? data_q[0] : in_rdata_i;
  assign w1 = valid_q[1] ? data_q[1][15:0] : in_rdata_i[15:0];
  assign a = valid_q[0] ? addr_q[0] : in_addr_i;
  assign a_next = a[ADDR_WIDTH-1:2] + (ADDR_WIDTH-2)'(1);
  assign out_addr_o = a;
  assign out_rdata_o = a[1] ? {w1, w0[31:16]} : w0;
  assign out_is_compressed_o = out_rdata_o[1:0] != 2'b11;
  assign out_valid_o = (~a[1] | (w0[17:16] != 2'b11)) ? (valid_q[0] | in_valid_i)
                                                      : (valid_q[1] | (valid_q[0] & in_valid_i));
  assign out_valid_stored_o = valid_q[0] & (~addr_q[0][1] | (data_q[0][17:16] != 2'b11) | valid_q[1]);
  assign in_ready_o = ~valid_q[DEPTH-2];
  assign pop = out_valid_o & out_ready_i;
  assign shift = a[1] | ~out_is_compressed_o;
  assign ua32 = a[1] & ~out_is_compressed_o;
  assign rep = in_valid_i & in_replace2_i & valid_q[0];
  assign overflow_o = ovf_q;
  always_comb begin
    valid_n = valid_q;
    addr_n = addr_q;
    data_n = data_q;
    ovf_n = ovf_q;
    placed = 1'b0;
    level_n = '0;
    if (rep) begin
      data_n[0] = out_rdata_o;
      addr_n[1] = in_addr_i;
      data_n[1] = in_rdata_i;
      valid_n = DEPTH'(2'b11);
    end else if (in_valid_i) begin
      for (int i = 0; i < DEPTH; i++)
        if (!valid_q[i] && !placed) begin
          valid_n[i] = 1'b1;
          addr_n[i] = in_addr_i;
          data_n[i] = in_rdata_i;
          placed = 1'b1;
        end
    end
    if (pop && shift) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        valid_n[i] = valid_n[i+1];
        addr_n[i] = addr_n[i+1];
        data_n[i] = data_n[i+1];
      end
      valid_n[DEPTH-1] = 1'b0;
      addr_n[DEPTH-1] = '0;
      data_n[DEPTH-1] = '0;
      // a stored successor word (e.g. a replace2 target) keeps its own address
      addr_n[0] = {(valid_n[0] ? addr_n[0][ADDR_WIDTH-1:2] : a_next), ua32, 1'b0};
      if (in_valid_i && !rep && !placed) begin
        valid_n[DEPTH-1] = 1'b1;
        addr_n[DEPTH-1] = in_addr_i;
        data_n[DEPTH-1] = in_rdata_i;
        placed = 1'b1;
      end
    end else if (pop) addr_n[0] = {a[ADDR_WIDTH-1:2], 2'b10};
    if (in_valid_i && !rep && !placed) ovf_n = 1'b1;
    if (clear_i) valid_n = '0;
    for (int i = 0; i < DEPTH; i++) level_n = level_n + LVL_W'(valid_n[i]);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid_q <= '0;
      ovf_q <= 1'b0;
      level_o <= '0;
      almost_full_o <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_n;
      addr_q <= addr_n;
      data_q <= data_n;
      ovf_q <= ovf_n;
      level_o <= level_n;
      almost_full_o <= level_n >= LVL_W'(AF_THRESH);
    end
endmodule

// File: tb/tb_riscv_fetch_fifo_gen.sv
// tb_riscv_fetch_fifo_gen: scoreboard bench for riscv_fetch_fifo_gen (DEPTH=4)
module tb_riscv_fetch_fifo_gen;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        c;
  } exp_t;
  logic clk = 1'b0;
  logic rst, clear, in_valid, in_ready, in_replace2, out_valid, out_ready;
  logic out_c, out_vs, af, ovf;
  logic [31:0] in_addr, in_rdata, out_rdata, out_addr;
  logic [2:0] level;
  int total = 0;
  int bad = 0;
  exp_t sb[$];
  exp_t e;
  riscv_fetch_fifo_gen #(.DEPTH(4), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .clear_i(clear), .in_addr_i(in_addr), .in_rdata_i(in_rdata),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_replace2_i(in_replace2),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_rdata_o(out_rdata),
    .out_addr_o(out_addr), .out_is_compressed_o(out_c), .out_valid_stored_o(out_vs),
    .level_o(level), .almost_full_o(af), .overflow_o(ovf)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected: got addr=%h data=%h, required no output", out_addr, out_rdata);
      end else begin
        e = sb.pop_front();
        if (out_addr !== e.addr || out_c !== e.c || (e.c ? out_rdata[15:0] !== e.data[15:0] : out_rdata !== e.data)) begin
          bad++;
          $display("FAIL pop: got addr=%h data=%h c=%b, required addr=%h data=%h c=%b",
                   out_addr, out_rdata, out_c, e.addr, e.data, e.c);
        end
      end
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic [31:0] ad, input logic [31:0] d);
    in_valid = 1'b1;
    in_addr = ad;
    in_rdata = d;
  endtask
  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; in_replace2 = 1'b0; out_ready = 1'b0;
    put(32'h40, 32'h13);
    #3;
    total++;
    if (level !== 3'd0 || af !== 1'b0 || ovf !== 1'b0 || out_vs !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_regs: got lvl=%0d af=%b ovf=%b vs=%b rdy=%b, required 0 0 0 0 1", level, af, ovf, out_vs, in_ready);
    end
    total++;
    if (out_valid !== 1'b1 || out_addr !== 32'h40 || out_rdata !== 32'h13) begin
      bad++;
      $display("FAIL reset_bypass: got v=%b a=%h d=%h, required 1 00000040 00000013", out_valid, out_addr, out_rdata);
    end
    tick();
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
  endtask
  task automatic test_aligned();
    out_ready = 1'b1;
    put(32'h100, 32'h00000413);
    sb.push_back('{32'h100, 32'h00000413, 1'b0});
    tick();
    put(32'h104, 32'h00100493);
    sb.push_back('{32'h104, 32'h00100493, 1'b0});
    tick();
    in_valid = 1'b0;
    total++;
    if (level !== 3'd0) begin
      bad++;
      $display("FAIL aligned_level: got %0d, required 0", level);
    end
  endtask
  task automatic test_compressed();
    out_ready = 1'b1;
    put(32'h200, 32'h45014501);
    sb.push_back('{32'h200, 32'h4501, 1'b1});
    tick();
    in_valid = 1'b0;
    sb.push_back('{32'h202, 32'h4501, 1'b1});
    total++;
    if (level !== 3'd1) begin
      bad++;
      $display("FAIL rvc_level_mid: got %0d, required 1", level);
    end
    tick();
    total++;
    if (level !== 3'd0) begin
      bad++;
      $display("FAIL rvc_level_end: got %0d, required 0", level);
    end
  endtask
  task automatic test_straddle();
    out_ready = 1'b1;
    put(32'h300, 32'h04134501);
    sb.push_back('{32'h300, 32'h4501, 1'b1});
    tick();
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_vs !== 1'b0 || out_addr !== 32'h302 || level !== 3'd1) begin
      bad++;
      $display("FAIL straddle_wait: got v=%b vs=%b a=%h lvl=%0d, required 0 0 00000302 1", out_valid, out_vs, out_addr, level);
    end
    tick();
    put(32'h304, 32'hABCD0000);
    sb.push_back('{32'h302, 32'h00000413, 1'b0});
    sb.push_back('{32'h306, 32'h0000ABCD, 1'b1});
    #1;
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL straddle_valid: got %b, required 1", out_valid);
    end
    tick();
    in_valid = 1'b0;
    total++;
    if (level !== 3'd1 || out_vs !== 1'b1 || out_addr !== 32'h306) begin
      bad++;
      $display("FAIL straddle_next: got lvl=%0d vs=%b a=%h, required 1 1 00000306", level, out_vs, out_addr);
    end
    tick();
    total++;
    if (level !== 3'd0) begin
      bad++;
      $display("FAIL straddle_end: got %0d, required 0", level);
    end
  endtask
  task automatic test_fill();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      put(32'h400 + 32'(4 * i), 32'h13 | (32'(i) << 7));
      if (i < 4) sb.push_back('{32'h400 + 32'(4 * i), 32'h13 | (32'(i) << 7), 1'b0});
      tick();
      total++;
      if (level !== 3'((i + 1 > 4) ? 4 : i + 1) || in_ready !== (i + 1 < 3) || af !== (i + 1 >= 3) || ovf !== (i == 4)) begin
        bad++;
        $display("FAIL fill_%0d: got lvl=%0d rdy=%b af=%b ovf=%b, required lvl=%0d rdy=%b af=%b ovf=%b", i, level, in_ready, af, ovf,
                 (i + 1 > 4) ? 4 : i + 1, i + 1 < 3, i + 1 >= 3, i == 4);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;
    total++;
    if (level !== 3'd0 || af !== 1'b0 || ovf !== 1'b1) begin
      bad++;
      $display("FAIL drain: got lvl=%0d af=%b ovf=%b, required 0 0 1", level, af, ovf);
    end
  endtask
  task automatic test_replace2();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      put(32'h500 + 32'(4 * i), 32'h00000013);
      tick();
    end
    sb.push_back('{32'h500, 32'h00000013, 1'b0});
    put(32'h800, 32'h00000093);
    in_replace2 = 1'b1;
    sb.push_back('{32'h800, 32'h00000093, 1'b0});
    tick();
    in_valid = 1'b0;
    in_replace2 = 1'b0;
    total++;
    if (level !== 3'd2 || out_addr !== 32'h500) begin
      bad++;
      $display("FAIL replace_level: got lvl=%0d a=%h, required 2 00000500", level, out_addr);
    end
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    total++;
    if (level !== 3'd0) begin
      bad++;
      $display("FAIL replace_end: got %0d, required 0", level);
    end
  endtask
  task automatic test_clear();
    out_ready = 1'b0;
    put(32'h600, 32'h13);
    tick();
    put(32'h604, 32'h13);
    tick();
    put(32'h608, 32'h13);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total++;
    if (level !== 3'd0 || out_vs !== 1'b0 || af !== 1'b0) begin
      bad++;
      $display("FAIL clear: got lvl=%0d vs=%b af=%b, required 0 0 0", level, out_vs, af);
    end
    put(32'h700, 32'h00000013);
    sb.push_back('{32'h700, 32'h00000013, 1'b0});
    tick();
    in_valid = 1'b0;
    total++;
    if (level !== 3'd1 || out_vs !== 1'b1) begin
      bad++;
      $display("FAIL after_clear: got lvl=%0d vs=%b, required 1 1", level, out_vs);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask
  task automatic test_async_reset();
    put(32'h900, 32'h13);
    tick();
    put(32'h904, 32'h13);
    tick();
    in_valid = 1'b0;
    total++;
    if (level !== 3'd2 || ovf !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset: got lvl=%0d ovf=%b, required 2 1", level, ovf);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (level !== 3'd0 || ovf !== 1'b0 || af !== 1'b0 || out_vs !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL async_reset: got lvl=%0d ovf=%b af=%b vs=%b rdy=%b, required 0 0 0 0 1", level, ovf, af, out_vs, in_ready);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_aligned();
    test_compressed();
    test_straddle();
    test_fill();
    test_replace2();
    test_clear();
    test_async_reset();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_left: got %0d pending, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
